// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter and scoreboard in front of the register file. It stages one write per cycle
// and tracks pending long-latency destinations. Define REGFILE_WB_BYPASS_EN to add forwarding outputs.
module regfile_wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [AW-1:0]         wb0_rd,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [AW-1:0]         wb1_rd,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic                  issue_ready,
  input  logic [AW-1:0]         rs1,
  input  logic [AW-1:0]         rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
`ifdef REGFILE_WB_BYPASS_EN
  output logic                  fwd1_valid,
  output logic                  fwd2_valid,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic [DATA_WIDTH-1:0] fwd2_data,
`endif
  output logic                  we3,
  output logic [AW-1:0]         a3,
  output logic [DATA_WIDTH-1:0] wd3
);

  logic                  last_grant_reg;  // 1: wb1 won the last contention
  logic [NUM_REGS-1:0]   busy_reg;
  logic [NUM_REGS-1:0]   busy_next;
  logic                  we3_reg;
  logic [AW-1:0]         a3_reg;
  logic [DATA_WIDTH-1:0] wd3_reg;

  logic                  wb_acc;
  logic [AW-1:0]         wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  always_comb begin
    wb0_ready   = wb0_valid && (!wb1_valid || last_grant_reg);
    wb1_ready   = wb1_valid && !wb0_ready;
    wb_acc      = wb0_ready || wb1_ready;
    wb_rd       = wb0_ready ? wb0_rd : wb1_rd;
    wb_data     = wb0_ready ? wb0_data : wb1_data;
    issue_ready = issue_valid && ((issue_rd == '0) || !busy_reg[issue_rd]);
  end

  // Issue set is checked before the wb1 clear so a same-cycle set wins.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = (issue_ready && (issue_rd == AW'(gi))) ? 1'b1 :
                               (wb1_ready && (wb1_rd == AW'(gi)))     ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg       <= '0;
      last_grant_reg <= 1'b1;
      we3_reg        <= 1'b0;
      a3_reg         <= '0;
      wd3_reg        <= '0;
    end else begin
      busy_reg <= busy_next;
      if (wb0_valid && wb1_valid)
        last_grant_reg <= wb1_ready;
      we3_reg <= wb_acc && (wb_rd != '0);
      if (wb_acc) begin
        a3_reg  <= wb_rd;
        wd3_reg <= wb_data;
      end
    end
  end

  assign we3 = we3_reg;
  assign a3  = a3_reg;
  assign wd3 = wd3_reg;

`ifdef REGFILE_WB_BYPASS_EN
  // The staged write is forwarded, so it no longer stalls decode.
  assign rs1_busy   = (rs1 != '0) && busy_reg[rs1];
  assign rs2_busy   = (rs2 != '0) && busy_reg[rs2];
  assign fwd1_valid = we3_reg && (a3_reg == rs1) && (rs1 != '0);
  assign fwd2_valid = we3_reg && (a3_reg == rs2) && (rs2 != '0);
  assign fwd1_data  = wd3_reg;
  assign fwd2_data  = wd3_reg;
`else
  assign rs1_busy = (rs1 != '0) && (busy_reg[rs1] || (we3_reg && (a3_reg == rs1)));
  assign rs2_busy = (rs2 != '0) && (busy_reg[rs2] || (we3_reg && (a3_reg == rs2)));
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed cover scenarios plus randomized traffic
// compared every cycle against a behavioural scoreboard model.
module tb_regfile_wb_ctrl;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = $clog2(NR);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [AW-1:0] wb0_rd, wb1_rd, issue_rd, rs1, rs2, a3;
  logic [DW-1:0] wb0_data, wb1_data, wd3;
  logic          issue_valid, issue_ready, rs1_busy, rs2_busy, we3;
`ifdef REGFILE_WB_BYPASS_EN
  logic          fwd1_valid, fwd2_valid;
  logic [DW-1:0] fwd1_data, fwd2_data;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef REGFILE_WB_BYPASS_EN
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
    .we3(we3), .a3(a3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending-destination set, next contention winner, staged write.
  bit          m_busy [NR];
  bit          m_next1;   // wb1 wins the next contention
  bit          m_we;
  bit          m_known;   // a3/wd3 have a defined expectation
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_wd;

  function automatic bit f_g0();
    return wb0_valid && (!wb1_valid || !m_next1);
  endfunction

  function automatic bit f_g1();
    return wb1_valid && !f_g0();
  endfunction

  function automatic bit f_issue();
    return issue_valid && (issue_rd == 0 || !m_busy[issue_rd]);
  endfunction

  function automatic bit f_rsb(input logic [AW-1:0] rs);
    return (rs != 0) && (m_busy[rs] || (!BYP && m_we && m_a == rs));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_busy[i] <= 1'b0;
      m_next1 <= 1'b0;
      m_we    <= 1'b0;
      m_a     <= '0;
      m_wd    <= '0;
      m_known <= 1'b1;
    end else begin
      if (f_g0()) begin
        m_we <= (wb0_rd != 0); m_a <= wb0_rd; m_wd <= wb0_data; m_known <= (wb0_rd != 0);
      end else if (f_g1()) begin
        m_we <= (wb1_rd != 0); m_a <= wb1_rd; m_wd <= wb1_data; m_known <= (wb1_rd != 0);
      end else begin
        m_we <= 1'b0;
      end
      if (wb0_valid && wb1_valid) m_next1 <= f_g0();
      if (f_g1()) m_busy[wb1_rd] <= 1'b0;
      if (f_issue() && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("wb0_ready", wb0_ready, f_g0());
    check("wb1_ready", wb1_ready, f_g1());
    check("issue_ready", issue_ready, f_issue());
    check("rs1_busy", rs1_busy, f_rsb(rs1));
    check("rs2_busy", rs2_busy, f_rsb(rs2));
    check("we3", we3, m_we);
    if (m_known) begin
      check("a3", a3, m_a);
      check("wd3", wd3, m_wd);
    end
`ifdef REGFILE_WB_BYPASS_EN
    check("fwd1_valid", fwd1_valid, m_we && m_a == rs1 && rs1 != 0);
    check("fwd2_valid", fwd2_valid, m_we && m_a == rs2 && rs2 != 0);
    if (m_we) begin
      check("fwd1_data", fwd1_data, m_wd);
      check("fwd2_data", fwd2_data, m_wd);
    end
`endif
  end

  task automatic idle();
    wb0_valid = 0; wb1_valid = 0; issue_valid = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; idle();
    wb0_rd = '0; wb1_rd = '0; issue_rd = '0; rs1 = '0; rs2 = '0;
    wb0_data = '0; wb1_data = '0;
    next_cycle();
    check("rst_we3", we3, 0);
    check("rst_a3", a3, 0);
    next_cycle();
    rst_n = 1;

    // Lone wb0 write
    next_cycle(); idle(); wb0_valid = 1; wb0_rd = 5; wb0_data = 32'hDEADBEEF;
    @(negedge clk); check("c21_ready", wb0_ready, 1);
    next_cycle(); idle();
    @(negedge clk);
    check("c21_we3", we3, 1); check("c21_a3", a3, 5); check("c21_wd3", wd3, 32'hDEADBEEF);

    // Four contended cycles alternate starting with wb0
    for (int k = 0; k < 4; k++) begin
      next_cycle(); idle(); wb0_valid = 1; wb1_valid = 1; wb0_rd = 3; wb1_rd = 4;
      wb0_data = $urandom; wb1_data = $urandom;
      @(negedge clk);
      check("c22_wb0", wb0_ready, (k % 2) == 0);
      check("c22_wb1", wb1_ready, (k % 2) == 1);
    end

    // Issue, WAW refusal, completion, staged write, then free
    next_cycle(); idle(); issue_valid = 1; issue_rd = 7; rs1 = 7;
    @(negedge clk); check("c23_iss", issue_ready, 1); check("c23_rs1a", rs1_busy, 0);
    next_cycle();
    @(negedge clk); check("c23_waw", issue_ready, 0); check("c23_rs1b", rs1_busy, 1);
    next_cycle(); idle(); wb1_valid = 1; wb1_rd = 7; wb1_data = 32'h55;
    @(negedge clk); check("c23_wb1", wb1_ready, 1); check("c23_rs1c", rs1_busy, 1);
    next_cycle(); idle();
    @(negedge clk); check("c23_rs1d", rs1_busy, !BYP);
`ifdef REGFILE_WB_BYPASS_EN
    check("c23_fwdv", fwd1_valid, 1); check("c23_fwdd", fwd1_data, 32'h55);
`endif
    next_cycle();
    @(negedge clk); check("c23_rs1e", rs1_busy, 0);

    // Write to x0 is accepted but never staged
    next_cycle(); idle(); wb0_valid = 1; wb0_rd = 0; wb0_data = 32'h1234;
    @(negedge clk); check("c24_ready", wb0_ready, 1);
    next_cycle(); idle();
    @(negedge clk); check("c24_we3", we3, 0);

    // Same-cycle issue and wb1 completion to r9: set wins
    next_cycle(); idle(); issue_valid = 1; issue_rd = 9; wb1_valid = 1; wb1_rd = 9;
    wb1_data = 32'h99; rs2 = 9;
    @(negedge clk); check("c25_iss", issue_ready, 1); check("c25_wb1", wb1_ready, 1);
    next_cycle(); idle();
    @(negedge clk); check("c25_rs2a", rs2_busy, 1);
    next_cycle();
    @(negedge clk); check("c25_rs2b", rs2_busy, 1);
    next_cycle(); wb1_valid = 1; wb1_rd = 9;
    next_cycle(); idle();

    // Reset with a staged write pending
    next_cycle(); wb0_valid = 1; wb0_rd = 6; wb0_data = 32'hA5A5; issue_valid = 1; issue_rd = 11;
    next_cycle(); idle();
    check("c26_staged", we3, 1);
    rst_n = 0; #1;
    check("c26_we3", we3, 0); check("c26_a3", a3, 0);
    next_cycle(); rst_n = 1; rs1 = 11; rs2 = 6;
    @(negedge clk);
    check("c26_rs1", rs1_busy, 0); check("c26_rs2", rs2_busy, 0); check("c26_we3b", we3, 0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst_n       = ($urandom_range(0, 199) != 0);
      wb0_valid   = $urandom_range(0, 1) == 1;
      wb1_valid   = $urandom_range(0, 2) == 0;
      issue_valid = $urandom_range(0, 2) == 0;
      wb0_rd      = AW'($urandom_range(0, 15));
      wb1_rd      = AW'($urandom_range(0, 15));
      issue_rd    = AW'($urandom_range(0, 15));
      rs1         = AW'($urandom_range(0, 15));
      rs2         = AW'($urandom_range(0, NR - 1));
      wb0_data    = $urandom;
      wb1_data    = $urandom;
    end
    next_cycle(); rst_n = 1; idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
